// File: rtl/alu_wb.sv
// Writeback stage behind the 4-bit ALU: queues each valid result in a small FIFO
// and keeps the HI/LO multiply registers, sticky add/sub flags and a result counter.
module alu_wb #(
    parameter int DEPTH = 4,
    parameter int W     = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [3:0]   aluop,
    input  logic [W-1:0] y0,
    input  logic [W-1:0] y1,
    input  logic [1:0]   ov,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [3:0]   out_aluop,
    output logic [W-1:0] out_y0,
    output logic [W-1:0] out_y1,
    output logic [1:0]   out_ov,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo,
    output logic         flag_ovf,
    output logic         flag_carry,
    input  logic         clr_flags,
    output logic [7:0]   op_count
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [3:0] OP_MULTU = 4'b1001;
    localparam logic [3:0] OP_MULT  = 4'b1010;
    localparam logic [3:0] OP_ADD   = 4'b1011;
    localparam logic [3:0] OP_SUB   = 4'b1100;

    typedef logic [AW:0] ptr_t;

    typedef struct packed {
        logic [3:0]   op;
        logic [W-1:0] y1;
        logic [W-1:0] y0;
        logic [1:0]   ov;
    } entry_t;

    entry_t       mem_q [DEPTH];
    ptr_t         wr_ptr_q, wr_ptr_d;
    ptr_t         rd_ptr_q, rd_ptr_d;
    logic [W-1:0] hi_q, lo_q;
    logic         ovf_q, ovf_d;
    logic         carry_q, carry_d;
    logic [7:0]   count_q, count_d;

    logic   full, empty, push, pop, mul_push, flag_push;
    entry_t head;

    // Both sides use valid/ready: a transfer happens on a rising edge where valid
    // and ready are both high. in_ready is !full (no bypass when full), out_valid
    // is !empty, and the head entry is presented combinationally from rd_ptr.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign push  = in_valid && !full;
    assign pop   = out_ready && !empty;

    assign mul_push  = push && ((aluop == OP_MULTU) || (aluop == OP_MULT));
    assign flag_push = push && ((aluop == OP_ADD) || (aluop == OP_SUB));

    assign head = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + ptr_t'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + ptr_t'(1) : rd_ptr_q;
        count_d  = push ? count_q + 8'd1 : count_q;
        // A flag-setting push in the same cycle as a clear takes priority.
        ovf_d    = (clr_flags ? 1'b0 : ovf_q)   | (flag_push & ov[1]);
        carry_d  = (clr_flags ? 1'b0 : carry_q) | (flag_push & ov[0]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            ovf_q    <= 1'b0;
            carry_q  <= 1'b0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q[AW-1:0]] <= {aluop, y1, y0, ov};
            end
            if (mul_push) begin
                hi_q <= y1;
                lo_q <= y0;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
            carry_q  <= carry_d;
            count_q  <= count_d;
        end
    end

    assign in_ready   = !full;
    assign out_valid  = !empty;
    assign out_aluop  = head.op;
    assign out_y0     = head.y0;
    assign out_y1     = head.y1;
    assign out_ov     = head.ov;
    assign hi         = hi_q;
    assign lo         = lo_q;
    assign flag_ovf   = ovf_q;
    assign flag_carry = carry_q;
    assign op_count   = count_q;

endmodule

// File: tb/tb_alu_wb.sv
// Directed bench for alu_wb: a queue-based model checked every negedge, plus
// hand-computed literal checks at key points of the sequence.
module tb_alu_wb;

  localparam int DEPTH = 4;
  localparam int W     = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   aluop = '0;
  logic [W-1:0] y0 = '0;
  logic [W-1:0] y1 = '0;
  logic [1:0]   ov = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [3:0]   out_aluop;
  logic [W-1:0] out_y0, out_y1;
  logic [1:0]   out_ov;
  logic [W-1:0] hi, lo;
  logic         flag_ovf, flag_carry;
  logic         clr_flags = 1'b0;
  logic [7:0]   op_count;

  alu_wb #(.DEPTH(DEPTH), .W(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .aluop(aluop), .y0(y0), .y1(y1), .ov(ov),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_aluop(out_aluop), .out_y0(out_y0), .out_y1(out_y1), .out_ov(out_ov),
    .hi(hi), .lo(lo), .flag_ovf(flag_ovf), .flag_carry(flag_carry),
    .clr_flags(clr_flags), .op_count(op_count)
  );

  // clock block
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model: FIFO as a queue of result tuples plus architectural state
  typedef struct packed {
    logic [3:0]   op;
    logic [W-1:0] y1;
    logic [W-1:0] y0;
    logic [1:0]   ov;
  } ent_t;

  ent_t         m_q[$];
  logic [W-1:0] m_hi, m_lo;
  logic         m_ovf, m_carry;
  int           m_count;
  logic         m_push, m_pop, m_flagop;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q.delete();
      m_hi = '0; m_lo = '0; m_ovf = 1'b0; m_carry = 1'b0; m_count = 0;
    end else begin
      m_push   = in_valid && (m_q.size() < DEPTH);
      m_pop    = out_ready && (m_q.size() > 0);
      m_flagop = m_push && (aluop == 4'b1011 || aluop == 4'b1100);
      if (m_push && (aluop == 4'b1001 || aluop == 4'b1010)) begin
        m_hi = y1; m_lo = y0;
      end
      m_ovf   = (clr_flags ? 1'b0 : m_ovf)   | (m_flagop & ov[1]);
      m_carry = (clr_flags ? 1'b0 : m_carry) | (m_flagop & ov[0]);
      if (m_pop) void'(m_q.pop_front());
      if (m_push) begin
        m_q.push_back('{op: aluop, y1: y1, y0: y0, ov: ov});
        m_count = (m_count + 1) % 256;
      end
    end
  end

  // scoreboard compare, every negedge outside reset
  ent_t exp_head;
  always @(negedge clk) begin
    if (!rst) begin
      exp_head = (m_q.size() > 0) ? m_q[0] : '0;
      check("out_valid", 32'(out_valid), 32'(m_q.size() != 0));
      check("in_ready", 32'(in_ready), 32'(m_q.size() < DEPTH));
      check("out_aluop", 32'(out_aluop), 32'(exp_head.op));
      check("out_y0", 32'(out_y0), 32'(exp_head.y0));
      check("out_y1", 32'(out_y1), 32'(exp_head.y1));
      check("out_ov", 32'(out_ov), 32'(exp_head.ov));
      check("hi", 32'(hi), 32'(m_hi));
      check("lo", 32'(lo), 32'(m_lo));
      check("flag_ovf", 32'(flag_ovf), 32'(m_ovf));
      check("flag_carry", 32'(flag_carry), 32'(m_carry));
      check("op_count", 32'(op_count), 32'(m_count));
    end
  end

  // driver: present one cycle of inputs, return 1 time unit after the edge
  task automatic cyc(input logic v, input logic [3:0] op, input logic [W-1:0] a0,
                     input logic [W-1:0] a1, input logic [1:0] o,
                     input logic rdy, input logic clr);
    in_valid = v; aluop = op; y0 = a0; y1 = a1; ov = o;
    out_ready = rdy; clr_flags = clr;
    @(posedge clk);
    #1;
    in_valid = 1'b0; out_ready = 1'b0; clr_flags = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // reset then idle
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_hi", 32'(hi), 32'd0);
    check("rst_lo", 32'(lo), 32'd0);
    check("rst_flags", {30'd0, flag_ovf, flag_carry}, 32'd0);
    check("rst_op_count", 32'(op_count), 32'd0);
    cyc(1'b0, 4'd0, 4'd0, 4'd0, 2'b00, 1'b0, 1'b0);

    // single ADD push, no consumer
    cyc(1'b1, 4'b1011, 4'b0101, 4'b0000, 2'b11, 1'b0, 1'b0);
    check("add_out_valid", 32'(out_valid), 32'd1);
    check("add_out_y0", 32'(out_y0), 32'h5);
    check("add_out_ov", 32'(out_ov), 32'h3);
    check("add_flags", {30'd0, flag_ovf, flag_carry}, 32'h3);
    check("add_op_count", 32'(op_count), 32'd1);
    cyc(1'b0, 4'd0, 4'd0, 4'd0, 2'b00, 1'b1, 1'b0);

    // MULTU then AND; HI/LO follow only the multiply
    cyc(1'b1, 4'b1001, 4'b1000, 4'b0010, 2'b00, 1'b0, 1'b0);
    cyc(1'b1, 4'b0000, 4'b0000, 4'b0000, 2'b01, 1'b0, 1'b0);
    check("mul_lo", 32'(lo), 32'h8);
    check("mul_hi", 32'(hi), 32'h2);
    check("mul_head_op", 32'(out_aluop), 32'h9);
    check("mul_flags_untouched", {30'd0, flag_ovf, flag_carry}, 32'h3);
    cyc(1'b0, 4'd0, 4'd0, 4'd0, 2'b00, 1'b1, 1'b0);
    check("and_head_op", 32'(out_aluop), 32'h0);
    check("and_head_ov", 32'(out_ov), 32'h1);
    cyc(1'b0, 4'd0, 4'd0, 4'd0, 2'b00, 1'b1, 1'b0);
    check("drained", 32'(out_valid), 32'd0);

    // clr_flags alone, then clear racing an ADD push
    cyc(1'b0, 4'd0, 4'd0, 4'd0, 2'b00, 1'b0, 1'b1);
    check("clr_flags", {30'd0, flag_ovf, flag_carry}, 32'h0);
    cyc(1'b1, 4'b1100, 4'h3, 4'h0, 2'b11, 1'b0, 1'b0);
    check("sub_flags", {30'd0, flag_ovf, flag_carry}, 32'h3);
    cyc(1'b1, 4'b1011, 4'h6, 4'h0, 2'b10, 1'b0, 1'b1);
    check("clr_vs_add_flags", {30'd0, flag_ovf, flag_carry}, 32'h2);
    cyc(1'b0, 4'd0, 4'd0, 4'd0, 2'b00, 1'b1, 1'b0);
    cyc(1'b0, 4'd0, 4'd0, 4'd0, 2'b00, 1'b1, 1'b0);

    // fill to full, then a push while full and draining is dropped
    for (int i = 0; i < DEPTH; i++)
      cyc(1'b1, 4'(i + 1), 4'(i), 4'(15 - i), 2'(i), 1'b0, 1'b0);
    check("full_in_ready", 32'(in_ready), 32'd0);
    check("full_op_count", 32'(op_count), 32'd9);
    cyc(1'b1, 4'hF, 4'hF, 4'hF, 2'b11, 1'b1, 1'b0);
    check("nobypass_op_count", 32'(op_count), 32'd9);
    check("nobypass_head_y0", 32'(out_y0), 32'h1);
    check("nobypass_in_ready", 32'(in_ready), 32'd1);

    // steady push/pop across pointer wrap
    for (int i = 0; i < 8; i++)
      cyc(1'b1, 4'(i), 4'(i + 4), 4'(i * 3), 2'(i + 1), 1'b1, 1'b0);
    check("wrap_op_count", 32'(op_count), 32'd17);
    check("wrap_head_y0", 32'(out_y0), 32'h9);

    // async reset mid-drain with 3 entries queued
    out_ready = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("async_out_valid", 32'(out_valid), 32'd0);
    check("async_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b0;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    check("post_rst_op_count", 32'(op_count), 32'd0);
    check("post_rst_out_y0", 32'(out_y0), 32'd0);

    cyc(1'b1, 4'b1010, 4'h7, 4'hC, 2'b01, 1'b0, 1'b0);
    check("post_rst_mult_hi", 32'(hi), 32'hC);
    cyc(1'b0, 4'd0, 4'd0, 4'd0, 2'b00, 1'b1, 1'b0);
    cyc(1'b0, 4'd0, 4'd0, 4'd0, 2'b00, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_wb.md
Name: alu_wb

Overview:
- Writeback/result stage directly downstream of the 4-bit combinational ALU.
- Each cycle the ALU result is valid, this block captures y0, y1, ov and aluop into a small result FIFO.
- It also maintains architectural HI/LO registers for multiply results and sticky overflow/carry flags for add/sub.
- FIFO contents drain to the display/consumer logic through a valid/ready handshake.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, minimum 2.
- W, 4, ALU data width for y0, y1, hi and lo.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  ALU result presented this cycle.
- in_ready  out  1  stage can accept; equals !full.
- aluop  in  4  opcode that produced the result.
- y0  in  W  ALU primary result (LO half for multiplies).
- y1  in  W  ALU secondary result (HI half for multiplies).
- ov  in  2  ALU status: ov[1] = signed overflow, ov[0] = carry/no-borrow.
- out_valid  out  1  FIFO head valid; equals !empty.
- out_ready  in  1  consumer takes the head this cycle.
- out_aluop  out  4  head entry opcode.
- out_y0  out  W  head entry y0.
- out_y1  out  W  head entry y1.
- out_ov  out  2  head entry ov.
- hi  out  W  HI register.
- lo  out  W  LO register.
- flag_ovf  out  1  sticky signed overflow.
- flag_carry  out  1  sticky carry.
- clr_flags  in  1  synchronous clear of both sticky flags.
- op_count  out  8  number of accepted results, wraps 255 -> 0.

Behaviour:
- Reset (async, immediate, independent of clk):
  - FIFO pointers and occupancy = 0, so out_valid = 0 and in_ready = 1.
  - hi, lo, flag_ovf, flag_carry, op_count = 0.
  - out_* data = 0 while empty; entries are cleared on reset.
  - Reset mid-operation discards all queued entries; no partial pop is completed.
- Push: occurs when in_valid && in_ready. Entry {aluop, y1, y0, ov} is written at wr_ptr, wr_ptr advances modulo DEPTH, and op_count increments.
- Pop: occurs when out_valid && out_ready. rd_ptr advances modulo DEPTH.
- Latency: push at edge N gives out_valid = 1 after edge N. There is no combinational fall-through from input to output.
- out_* are read combinationally from the entry at rd_ptr.
- Simultaneous push and pop: allowed whenever not full and not empty. Occupancy is unchanged; order is preserved.
- Full: in_ready = 0, and in_valid is ignored even if out_ready = 1 in the same cycle (no bypass). Upstream must hold its data.
- Empty: out_ready is ignored; pointers do not move.
- Pointer wrap-around: pointers are log2(DEPTH) bits plus a wrap bit. full = equal index with differing wrap bits; empty = equal pointers.
- HI/LO: on push with aluop = 4'b1001 (MULTU) or 4'b1010 (MULT), lo <= y0 and hi <= y1. Other opcodes leave hi and lo unchanged.
- Sticky flags: on push with aluop = 4'b1011 (ADD) or 4'b1100 (SUB), flag_ovf <= flag_ovf | ov[1] and flag_carry <= flag_carry | ov[0]. ov from other opcodes is queued but does not touch the flags.
- clr_flags in the same cycle as a flag-setting push: the new event wins, so the flag equals ov bit of that push; otherwise the flag clears to 0.
- No arithmetic on data: values pass through bit-exact.

Test Plan:
- Reset then idle:
  - out_valid = 0, in_ready = 1, hi = lo = 0, flags = 0, op_count = 0.
- Single push of ADD result (y0 = 4'b0101, ov = 2'b11) with out_ready = 0:
  - next cycle out_valid = 1, out_y0 = 4'b0101, out_ov = 2'b11, flag_ovf = 1, flag_carry = 1, op_count = 1.
- Push MULTU (y0 = 4'b1000, y1 = 4'b0010), then AND (y0 = 4'b0000):
  - lo = 4'b1000, hi = 4'b0010, unchanged after the AND.
  - Popping returns the MULTU entry first, then the AND entry.
- Fill and wrap:
  - Push 4 entries with out_ready = 0: in_ready = 0 after the 4th, and a 5th push is ignored while out_ready = 1 in that same cycle.
  - Continue with 8 more push/pop cycles: data order is preserved across pointer wrap.
- clr_flags cases:
  - clr_flags alone with flags = 1: both flags = 0 next cycle.
  - clr_flags together with push of ADD ov = 2'b10: flag_ovf = 1, flag_carry = 0.
- Async reset asserted mid-drain with 3 entries queued:
  - out_valid drops immediately without a clock edge.
  - After release, in_ready = 1 and op_count = 0.
